// File: rtl/q2_panel_input.sv
// Front-panel input conditioner for the q2 CPU: synchronises and debounces the raw panel
// switches into a stable 12-bit word and one-clock button strobes. Optional incp auto-repeat: Q2_PANEL_AUTOREPEAT_EN.
module q2_panel_input #(
  parameter int DEBOUNCE_CYCLES = 800,
  parameter int SYNC_STAGES     = 2,
  parameter int REPEAT_CYCLES   = 24000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] sw_in,
  input  logic        incp_in,
  input  logic        dep_in,
  input  logic        start_in,
  input  logic        stop_in,
  input  logic        run,
  output logic [11:0] sw,
  output logic        incp_pulse,
  output logic        dep_pulse,
  output logic        start_pulse,
  output logic        stop_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam int unsigned NB = 4;

  typedef enum logic [1:0] {IDLE, PRESS, HELD, RELEASE} btn_state_t;

  if (DEBOUNCE_CYCLES < 1 || SYNC_STAGES < 2 || REPEAT_CYCLES < 1) begin : g_bad_cfg
    $error("q2_panel_input: invalid parameter set");
  end

  // Bit layout of the synchronised vector: [15:12] = stop, start, dep, incp; [11:0] = data switches.
  logic [15:0] sync_q [SYNC_STAGES];
  logic [15:0] s;
  logic [3:0]  btn;

  assign s   = sync_q[SYNC_STAGES-1];
  assign btn = s[15:12];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {stop_in, start_in, dep_in, incp_in, sw_in};
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  btn_state_t    state [NB];
  logic [CW-1:0] cnt   [NB];
  logic [NB-1:0] accept;

  always_comb begin
    accept = '0;
    for (int unsigned i = 0; i < NB; i++)
      accept[i] = (state[i] == PRESS) && btn[i] && (cnt[i] == CNT_LAST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NB; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NB; i++) begin
        case (state[i])
          IDLE: begin
            if (btn[i]) begin
              state[i] <= PRESS;
              cnt[i]   <= '0;
            end
          end
          PRESS: begin
            if (!btn[i])                state[i] <= IDLE;
            else if (cnt[i] == CNT_LAST) state[i] <= HELD;
            else                         cnt[i]   <= cnt[i] + CW'(1);
          end
          HELD: begin
            if (!btn[i]) begin
              state[i] <= RELEASE;
              cnt[i]   <= '0;
            end
          end
          RELEASE: begin
            if (btn[i])                  state[i] <= HELD;
            else if (cnt[i] == CNT_LAST) state[i] <= IDLE;
            else                         cnt[i]   <= cnt[i] + CW'(1);
          end
          default: state[i] <= IDLE;
        endcase
      end
    end
  end

  logic repeat_fire;

`ifdef Q2_PANEL_AUTOREPEAT_EN
  localparam int RPW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RPW-1:0] REP_LAST = RPW'(REPEAT_CYCLES - 1);

  logic [RPW-1:0] rep_cnt;
  logic           rep_active;

  // Counts only while incp stays in HELD; leaving HELD or run=1 restarts the period.
  assign rep_active  = (state[0] == HELD) && btn[0] && !run;
  assign repeat_fire = rep_active && (rep_cnt == REP_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             rep_cnt <= '0;
    else if (!rep_active) rep_cnt <= '0;
    else if (repeat_fire) rep_cnt <= '0;
    else                  rep_cnt <= rep_cnt + RPW'(1);
  end
`else
  assign repeat_fire = 1'b0;
`endif

  logic [11:0]   shadow;
  logic [CW-1:0] sw_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow      <= '0;
      sw_cnt      <= '0;
      sw          <= '0;
      incp_pulse  <= 1'b0;
      dep_pulse   <= 1'b0;
      start_pulse <= 1'b0;
      stop_pulse  <= 1'b0;
    end else begin
      incp_pulse  <= (accept[0] | repeat_fire) & ~run;
      dep_pulse   <= accept[1] & ~run;
      start_pulse <= accept[2] & ~accept[3];
      stop_pulse  <= accept[3];
      // sw only ever loads the whole shadow word, so a partial update is never visible.
      if (s[11:0] != shadow) begin
        shadow <= s[11:0];
        sw_cnt <= '0;
      end else if (sw_cnt == CNT_LAST) begin
        sw <= shadow;
      end else begin
        sw_cnt <= sw_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_q2_panel_input.sv
// Self-checking bench for q2_panel_input: directed scenarios plus random stimulus,
// checked against a run-length debounce model of the panel behaviour.
module tb_q2_panel_input;

  localparam int D = 4;
  localparam int S = 2;
  localparam int R = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] sw_in;
  logic        incp_in, dep_in, start_in, stop_in, run;
  logic [11:0] sw;
  logic        incp_pulse, dep_pulse, start_pulse, stop_pulse;

  int checks = 0;
  int failures = 0;

  q2_panel_input #(
    .DEBOUNCE_CYCLES(D),
    .SYNC_STAGES(S),
    .REPEAT_CYCLES(R)
  ) dut (
    .clk(clk), .rst(rst), .sw_in(sw_in),
    .incp_in(incp_in), .dep_in(dep_in), .start_in(start_in), .stop_in(stop_in),
    .run(run), .sw(sw),
    .incp_pulse(incp_pulse), .dep_pulse(dep_pulse),
    .start_pulse(start_pulse), .stop_pulse(stop_pulse)
  );

  always #5 clk = ~clk;

  // Reference model: a synchronised level is accepted once it has differed from the
  // debounced level for D+1 consecutive samples; the word is accepted after D quiet samples.
  bit [15:0] m_hist [S];
  bit [15:0] m_s;
  bit        m_lvl [4];
  int        m_run [4];
  bit [3:0]  m_acc;
  bit        m_rep;
  int        m_rep_cnt;
  bit [11:0] m_shadow;
  int        m_age;
  bit [11:0] exp_sw;
  bit        exp_incp, exp_dep, exp_start, exp_stop;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < S; i++) m_hist[i] = '0;
      for (int i = 0; i < 4; i++) begin m_lvl[i] = 0; m_run[i] = 0; end
      m_rep_cnt = 0; m_shadow = '0; m_age = 0; exp_sw = '0;
      exp_incp = 0; exp_dep = 0; exp_start = 0; exp_stop = 0;
    end else begin
      m_s = m_hist[S-1];
      for (int i = S-1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = {stop_in, start_in, dep_in, incp_in, sw_in};
      m_acc = '0;
      m_rep = 0;
`ifdef Q2_PANEL_AUTOREPEAT_EN
      if (m_lvl[0] && m_run[0] == 0 && m_s[12] && !run) begin
        m_rep_cnt++;
        if (m_rep_cnt == R) begin m_rep = 1; m_rep_cnt = 0; end
      end else m_rep_cnt = 0;
`endif
      for (int i = 0; i < 4; i++) begin
        if (m_s[12+i] != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == D + 1) begin
            m_lvl[i] = ~m_lvl[i];
            m_run[i] = 0;
            m_acc[i] = m_lvl[i];
          end
        end else m_run[i] = 0;
      end
      if (m_s[11:0] != m_shadow) begin
        m_shadow = m_s[11:0];
        m_age = 0;
      end else begin
        if (m_age < D) m_age++;
        if (m_age >= D) exp_sw = m_shadow;
      end
      exp_incp  = (m_acc[0] | m_rep) & ~run;
      exp_dep   = m_acc[1] & ~run;
      exp_start = m_acc[2] & ~m_acc[3];
      exp_stop  = m_acc[3];
    end
  end

  logic [15:0] obs, exp_v;
  assign obs   = {sw, incp_pulse, dep_pulse, start_pulse, stop_pulse};
  assign exp_v = {exp_sw, exp_incp, exp_dep, exp_start, exp_stop};

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; run = 1'b0; sw_in = 12'hFFF;
    incp_in = 1; dep_in = 1; start_in = 1; stop_in = 1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      checks++;
      if (obs !== 16'h0000) begin
        failures++; $display("FAIL reset_hold k=%0d got=%h exp=0000", k, obs);
      end
    end
    @(negedge clk); rst = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      checks++;
      if ({incp_pulse, dep_pulse, start_pulse, stop_pulse} !== ((k == 6) ? 4'b1101 : 4'b0000)) begin
        failures++; $display("FAIL reset_release k=%0d got=%b", k, {incp_pulse, dep_pulse, start_pulse, stop_pulse});
      end
      checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL reset_model k=%0d got=%h exp=%h", k, obs, exp_v);
      end
    end
    @(negedge clk); incp_in = 0; dep_in = 0; start_in = 0; stop_in = 0; sw_in = '0;
    idle(15);
  endtask

  task automatic test_start_latency();
    @(negedge clk); start_in = 1;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      checks++;
      if (start_pulse !== 1'(k == 6)) begin
        failures++; $display("FAIL start_latency k=%0d got=%b exp=%b", k, start_pulse, (k == 6));
      end
      checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL start_model k=%0d got=%h exp=%h", k, obs, exp_v);
      end
    end
    @(negedge clk); start_in = 0;
    idle(12);
  endtask

  task automatic test_bounce();
    int n;
    n = 0;
    run = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      dep_in = (k < 20) ? ((k / 2) % 2 == 0) : 1'b1;
      sw_in  = 12'($urandom);
      @(posedge clk); #1;
      n += int'(dep_pulse);
      checks++;
      if (dep_pulse !== 1'(k == 26)) begin
        failures++; $display("FAIL bounce_press k=%0d got=%b exp=%b", k, dep_pulse, (k == 26));
      end
      checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL bounce_model k=%0d got=%h exp=%h", k, obs, exp_v);
      end
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      dep_in = (k < 20) ? ((k / 2) % 2 == 1) : 1'b0;
      @(posedge clk); #1;
      n += int'(dep_pulse);
      checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL bounce_rel_model k=%0d got=%h exp=%h", k, obs, exp_v);
      end
    end
    checks++;
    if (n != 1) begin
      failures++; $display("FAIL bounce_count got=%0d exp=1", n);
    end
    idle(5);
  endtask

  task automatic test_collision();
    int n_start, n_stop;
    n_start = 0; n_stop = 0;
    @(negedge clk); start_in = 1; stop_in = 1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      n_start += int'(start_pulse);
      n_stop  += int'(stop_pulse);
      checks++;
      if (stop_pulse !== 1'(k == 6)) begin
        failures++; $display("FAIL collision_stop k=%0d got=%b exp=%b", k, stop_pulse, (k == 6));
      end
    end
    checks++;
    if (n_start != 0 || n_stop != 1) begin
      failures++; $display("FAIL collision_count start=%0d stop=%0d exp start=0 stop=1", n_start, n_stop);
    end
    @(negedge clk); start_in = 0; stop_in = 0;
    idle(12);
  endtask

  task automatic test_run_gate();
    int n, exp_n;
    bit e;
    n = 0;
    @(negedge clk); run = 1; incp_in = 1;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      checks++;
      if (incp_pulse !== 1'b0) begin
        failures++; $display("FAIL run_block k=%0d got=%b exp=0", k, incp_pulse);
      end
    end
    @(negedge clk); incp_in = 0;
    idle(12);
    @(negedge clk); run = 0;
    @(negedge clk); incp_in = 1;
    for (int k = 0; k < 42; k++) begin
      @(posedge clk); #1;
      e = (k == 6);
`ifdef Q2_PANEL_AUTOREPEAT_EN
      e = e || (k > 6 && k <= 36 && (k - 6) % R == 0);
`endif
      n += int'(incp_pulse);
      checks++;
      if (incp_pulse !== e) begin
        failures++; $display("FAIL run_gate_incp k=%0d got=%b exp=%b", k, incp_pulse, e);
      end
    end
`ifdef Q2_PANEL_AUTOREPEAT_EN
    exp_n = 4;
`else
    exp_n = 1;
`endif
    checks++;
    if (n != exp_n) begin
      failures++; $display("FAIL run_gate_count got=%0d exp=%0d", n, exp_n);
    end
    @(negedge clk); incp_in = 0;
    idle(12);
  endtask

  task automatic test_sw_word();
    @(negedge clk); sw_in = 12'hA5C;
    idle(12);
    #1;
    checks++;
    if (sw !== 12'hA5C) begin
      failures++; $display("FAIL sw_settle got=%h exp=a5c", sw);
    end
    @(negedge clk); sw_in = 12'h123;
    repeat (3) @(negedge clk);
    sw_in = 12'hA5C;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      checks++;
      if (sw !== 12'hA5C) begin
        failures++; $display("FAIL sw_glitch k=%0d got=%h exp=a5c", k, sw);
      end
    end
    @(negedge clk); sw_in = 12'h123;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      checks++;
      if (sw !== ((k >= 6) ? 12'h123 : 12'hA5C)) begin
        failures++; $display("FAIL sw_update k=%0d got=%h", k, sw);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 800; k++) begin
      @(negedge clk);
      if ($urandom_range(0, 9) == 0) incp_in  = ~incp_in;
      if ($urandom_range(0, 9) == 0) dep_in   = ~dep_in;
      if ($urandom_range(0, 9) == 0) start_in = ~start_in;
      if ($urandom_range(0, 9) == 0) stop_in  = ~stop_in;
      if ($urandom_range(0, 39) == 0) run = ~run;
      if ($urandom_range(0, 15) == 0) sw_in = 12'($urandom);
      else if ($urandom_range(0, 19) == 0) sw_in[$urandom_range(0, 11)] ^= 1'b1;
      if (k == 400) rst = 1'b0;
      if (k == 403) rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL random_model k=%0d got=%h exp=%h", k, obs, exp_v);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_start_latency();
    test_bounce();
    test_collision();
    test_run_gate();
    test_sw_word();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
